// File: rtl/ysyx_23060240_sram_resp.sv
// ysyx_23060240_sram_resp
//
// Memory-side responder for the instruction-fetch and load/store master.
// Services one AXI4-Lite-style read or write at a time from an internal
// word array. The response appears LAT+1 cycles after the request handshake.
//
// Parameters:
//   BASE   byte address of word 0
//   DEPTH  number of 32-bit words in the array
//   LAT    wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   araddr/arvalid/arready        read request channel
//   rdata/rresp/rvalid/rready     read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel (wstrb bit i -> byte i)
//   bresp/bvalid/bready           write response channel (bresp 00 OKAY, 10 SLVERR)
//
// Every handshake output is registered. The readies are only ever high in
// IDLE, and arready is never high together with awready/wready. That
// exclusivity gives a write priority over a read that arrives in the same
// cycle without ever dropping a read handshake.
module ysyx_23060240_sram_resp #(
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   // read address
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   // read data
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   // write address
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   // write data
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   // write response
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned Iw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Byte span of the array. This is one bit wider than an address, so the
   // top of a 4 GiB window cannot overflow.
   localparam logic [32:0] Span   = 33'(DEPTH) << 2;
   localparam logic [1:0]  RespOk = 2'b00;
   localparam logic [1:0]  RespSe = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StRdWait,
      StRdResp,
      StWrWait,
      StWrResp
   } state_e;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;

   logic [31:0]   mem [DEPTH];

   logic          wr_req;
   logic          wr_hs;
   logic          rd_hs;
   logic [31:0]   off;
   logic          in_range;
   logic [Iw-1:0] idx;
   logic          do_write;

   always_comb begin
      wr_req   = awvalid && wvalid;
      // Ready outputs are 0 outside IDLE, so these can only fire in IDLE.
      wr_hs    = wr_req && awready && wready;
      rd_hs    = arvalid && arready;
      // An address below BASE wraps to a large offset and fails the range test.
      off      = addr_q - BASE;
      in_range = ({1'b0, off} < Span);
      idx      = off[Iw+1:2];
      do_write = (state_q == StWrWait) && (cnt_q == 4'd0) && in_range;
   end

   // Control FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         arready <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         rvalid  <= 1'b0;
         bvalid  <= 1'b0;
         rdata   <= 32'd0;
         rresp   <= 2'b00;
         bresp   <= 2'b00;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_hs) begin
                  addr_q  <= awaddr;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
                  cnt_q   <= 4'(LAT);
                  state_q <= StWrWait;
                  arready <= 1'b0;
                  awready <= 1'b0;
                  wready  <= 1'b0;
               end else if (rd_hs) begin
                  addr_q  <= araddr;
                  cnt_q   <= 4'(LAT);
                  state_q <= StRdWait;
                  arready <= 1'b0;
                  awready <= 1'b0;
                  wready  <= 1'b0;
               end else begin
                  // Offer the read channel only when a read is asking and no
                  // complete write is waiting. Otherwise offer the write
                  // channels. The two are never offered together.
                  arready <= arvalid && !wr_req;
                  awready <= !(arvalid && !wr_req);
                  wready  <= !(arvalid && !wr_req);
               end
            end

            StRdWait: begin
               if (cnt_q == 4'd0) begin
                  rdata   <= in_range ? mem[idx] : 32'd0;
                  rresp   <= in_range ? RespOk : RespSe;
                  rvalid  <= 1'b1;
                  state_q <= StRdResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            StRdResp: begin
               // rdata and rresp stay untouched until the handshake.
               if (rready) begin
                  rvalid  <= 1'b0;
                  state_q <= StIdle;
               end
            end

            StWrWait: begin
               if (cnt_q == 4'd0) begin
                  bresp   <= in_range ? RespOk : RespSe;
                  bvalid  <= 1'b1;
                  state_q <= StWrResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            StWrResp: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  state_q <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
               arready <= 1'b0;
               awready <= 1'b0;
               wready  <= 1'b0;
               rvalid  <= 1'b0;
               bvalid  <= 1'b0;
            end
         endcase
      end
   end

   // The array keeps its contents across reset. The write is committed in the
   // same cycle the FSM leaves WR_WAIT, so a read accepted after bvalid sees it.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
               mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_sram_resp.sv
module tb_ysyx_23060240_sram_resp;

   localparam int unsigned LAT   = 2;
   localparam int unsigned BOUND = 50;

   logic        clk;
   logic        rst_n;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   ysyx_23060240_sram_resp #(
      .BASE  (32'h8000_0000),
      .DEPTH (4096),
      .LAT   (LAT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no response within %0d cycles", name, BOUND);
   endtask

   // Monitor: pops the oldest expectation at every response handshake.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (rvalid && rready) begin
            if (sb.size() == 0) begin
               timeout("unexpected_r");
            end else begin
               e = sb.pop_front();
               chk("r_kind", 32'(e.is_rd), 32'd1);
               chk("rdata", rdata, e.data);
               chk("rresp", 32'(rresp), 32'(e.resp));
            end
         end
         if (bvalid && bready) begin
            if (sb.size() == 0) begin
               timeout("unexpected_b");
            end else begin
               e = sb.pop_front();
               chk("b_kind", 32'(e.is_rd), 32'd0);
               chk("bresp", 32'(bresp), 32'(e.resp));
            end
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      int k;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      k = 0;
      while (!(awready && wready) && k < BOUND) begin @(negedge clk); k++; end
      if (k >= BOUND) begin
         timeout("aw_w_accept");
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      sb.push_back('{is_rd: 1'b0, data: 32'd0, resp: exp_resp});
      @(negedge clk);
      // Change the request inputs after the handshake; they must be ignored.
      awvalid = 1'b0; wvalid = 1'b0; awaddr = 32'hFFFF_FFFF; wdata = ~data; wstrb = 4'hF;
      k = 0;
      while (!bvalid && k < BOUND) begin @(negedge clk); k++; end
      chk("b_latency", 32'(k), 32'(LAT + 1));
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
      int k;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      k = 0;
      while (!arready && k < BOUND) begin @(negedge clk); k++; end
      if (k >= BOUND) begin
         timeout("ar_accept");
         arvalid = 1'b0;
         return;
      end
      sb.push_back('{is_rd: 1'b1, data: exp_data, resp: exp_resp});
      @(negedge clk);
      arvalid = 1'b0; araddr = 32'h8000_0004;
      k = 0;
      while (!rvalid && k < BOUND) begin @(negedge clk); k++; end
      chk("r_latency", 32'(k), 32'(LAT + 1));
      for (int i = 0; i < hold; i++) begin
         chk("r_hold_valid", 32'(rvalid), 32'd1);
         chk("r_hold_data", rdata, exp_data);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      int k;
      logic ar_seen;
      logic rv_seen;

      rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      rst_n = 1'b1;

      // Write, then read back under 4 cycles of backpressure
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
      do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 4);

      // Byte strobe, plus unaligned address aliasing the same word
      do_write(32'h8000_0010, 32'h0000_00AA, 4'h1, 2'b00);
      do_read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 0);
      do_read(32'h8000_0013, 32'hDEAD_BEAA, 2'b00, 0);

      // Simultaneous read and write to the same word: the write goes first
      ar_seen = 1'b0;
      @(negedge clk);
      araddr = 32'h8000_0020; arvalid = 1'b1;
      awaddr = 32'h8000_0020; wdata = 32'h5555_AAAA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      k = 0;
      while (!(awready && wready) && k < BOUND) begin
         ar_seen |= arready; @(negedge clk); k++;
      end
      ar_seen |= arready;
      if (k >= BOUND) timeout("simul_aw_accept");
      sb.push_back('{is_rd: 1'b0, data: 32'd0, resp: 2'b00});
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      k = 0;
      while (!bvalid && k < BOUND) begin ar_seen |= arready; @(negedge clk); k++; end
      ar_seen |= arready;
      chk("simul_b_latency", 32'(k), 32'(LAT + 1));
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("simul_arready_during_write", 32'(ar_seen), 32'd0);
      chk("simul_arready_after_b", 32'(arready), 32'd0);
      sb.push_back('{is_rd: 1'b1, data: 32'h5555_AAAA, resp: 2'b00});
      @(negedge clk);
      chk("simul_arready_plus1", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < BOUND) begin @(negedge clk); k++; end
      chk("simul_r_latency", 32'(k), 32'(LAT + 1));
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;

      // Out of range accesses
      do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00);
      do_read(32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 0);
      do_write(32'h8000_4000, 32'h1234_5678, 4'hF, 2'b10);
      do_read(32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);
      do_read(32'h8000_3FFC, 32'h0000_0000, 2'b00, 0);

      // Reset during RD_WAIT drops the read
      @(negedge clk);
      araddr = 32'h8000_0010; arvalid = 1'b1;
      k = 0;
      while (!arready && k < BOUND) begin @(negedge clk); k++; end
      if (k >= BOUND) timeout("midrst_ar_accept");
      @(negedge clk);
      arvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_arready", 32'(arready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rready = 1'b1;
      rv_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); rv_seen |= rvalid; end
      rready = 1'b0;
      chk("midrst_no_response", 32'(rv_seen), 32'd0);
      do_read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_23060240_sram_resp.md
Name: ysyx_23060240_sram_resp

Overview:
- Memory-side responder for the core's instruction-fetch and load/store master.
- Accepts read and write requests over an AXI4-Lite-style valid/ready handshake, with separate AR/R/AW/W/B channels.
- Services each request from an internal word array after a programmable latency.
- Replaces the zero-latency combinational pmem_read path with a cycle-accurate, synthesizable slave.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words in the array.
- LAT, 2, wait cycles between request acceptance and response valid; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- araddr  in  32  read byte address
- arvalid  in  1  read request valid
- arready  out  1  read request accepted
- rdata  out  32  read word
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  master accepts read data
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write word
- wstrb  in  4  byte-enable mask; bit i enables wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  master accepts write response

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; the latency counter clears.
  - All outputs go to 0: arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp.
  - Array contents are not cleared.
- Reset asserted mid-transaction drops that transaction; no response is ever issued for it.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP. One outstanding transaction at a time.
- Ready outputs are registered:
  - arready is high only in IDLE when no write is pending.
  - awready and wready are high only in IDLE.
- Request acceptance in IDLE:
  - A write is accepted only when awvalid and wvalid are both high. AW and W handshake in the same cycle; a lone awvalid or wvalid is not accepted.
  - If a write and arvalid are both present in the same cycle, the write wins. The read stays pending, and arready remains low that cycle.
  - Read accepted (arvalid and arready) -> latch the address, load counter = LAT, go to RD_WAIT.
  - Write accepted -> latch addr, data and strb, load counter = LAT, go to WR_WAIT.
- RD_WAIT / WR_WAIT:
  - The counter decrements each cycle.
  - At counter == 0, the array access occurs and the FSM moves to RD_RESP / WR_RESP, asserting rvalid / bvalid the next cycle.
  - With LAT = 0, rvalid / bvalid rise exactly 1 cycle after the request handshake. In general the latency is LAT+1 cycles.
- RD_RESP:
  - rdata and rresp are held stable while rvalid is high and rready is low.
  - On rvalid and rready: clear rvalid, return to IDLE. arready may reassert no earlier than the following cycle.
- WR_RESP:
  - bvalid is held until bready. On the handshake: clear bvalid, return to IDLE.
- Addressing:
  - word index = (addr - BASE) >> 2. addr[1:0] is ignored (word-aligned access).
  - In range means BASE <= addr < BASE + 4*DEPTH. Index width is clog2(DEPTH).
- Out of range:
  - Read returns rdata = 0, rresp = 10.
  - Write does not modify the array and returns bresp = 10.
  - Latency is unchanged.
- Writes update only the byte lanes enabled in wstrb. wstrb = 0 is legal: no modification, bresp = 00.
- Read-after-write: a read accepted after a write's bvalid handshake returns the new data.
- Inputs are sampled only on handshake cycles. Master changes to address/data while the block is busy have no effect.

Test Plan:
- Reset then write: hold rst_n low for 3 cycles and check all outputs are 0. Then write addr 8000_0010, data DEADBEEF, strb F -> bvalid high 3 cycles after the AW/W handshake (LAT=2), bresp = 00.
- Read back and backpressure: read 8000_0010 with rready held low for 4 cycles -> rvalid stays high and rdata stays DEADBEEF throughout; handshake completes on rready.
- Byte strobe: write 8000_0010 data 0000_00AA, strb 0001 -> subsequent read returns DEADBEAA. Also check a read of 8000_0013 returns the same word.
- Simultaneous requests: assert arvalid and awvalid/wvalid in the same cycle.
  - Required order: the write is serviced first; arready stays low until write completion plus 1 cycle.
  - The read then returns the written value.
- Out of range: read 7FFF_FFFC -> rresp = 10, rdata = 0. Write 8000_4000 -> bresp = 10, and word 0 is unchanged.
- Mid-operation reset: assert rst_n low during RD_WAIT -> rvalid never asserts. After release, arready returns high and a fresh read completes normally.
